npu_bus_master: RTL and testbench
=================================

# npu_bus_master

Bus initiator that drives one NPU activation job over the single-master/single-slave NPU register bus. It accepts a command of activation type plus input word, then issues a pipelined transfer sequence: write Type (0x0), write Input (0x4), read Output (0x8). It returns the result on a valid/ready response port. It sits between a host-side command source and the NPU slave top, and drives the slave's bus inputs.

## Interface

Parameters
- DWidth, 32, bus data/address width
- TypeAddr, 'h0, type register address
- InputAddr, 'h4, input register address
- OutputAddr, 'h8, output register address

Ports
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_type_i  in  DWidth  activation type to write
- cmd_data_i  in  DWidth  activation input to write
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  result consumed when valid&ready
- rsp_data_o  out  DWidth  read-back output word (0 on error)
- rsp_err_o  out  1  any transfer of the job got resp_i=1
- sel_o  out  1  slave select (address phase)
- trans_o  out  1  1=active transfer, 0=idle
- write_o  out  1  1=write, 0=read
- addr_o  out  DWidth  transfer address
- wdata_o  out  DWidth  write data (data phase)
- ready_o  out  1  bus ready to slave; combinational copy of ready_i
- rdata_i  in  DWidth  slave read data
- resp_i  in  1  slave error response, valid when ready_i=1
- ready_i  in  1  slave ready; 1 completes current data phase

## Operation

- FSM states: IDLE, A_TYPE, A_INPUT, A_READ, D_READ, RESP.
- IDLE: cmd_ready_o=1. Bus idle (sel_o=trans_o=0). On cmd_valid_i, latch type/data. Go to A_TYPE. If the type cache is valid and cmd_type_i equals the cached type, go to A_INPUT instead.
- A_TYPE: address phase, sel/trans/write=1, addr=TypeAddr.
- A_INPUT: address phase, write, addr=InputAddr. Data phase of type write if previous state was A_TYPE (wdata_o=type).
- A_READ: address phase, read, addr=OutputAddr. Data phase of input write (wdata_o=data).
- D_READ: trans_o=sel_o=0. On ready_i=1, capture rdata_i.
- RESP: rsp_valid_o=1, held stable until rsp_ready_i. Then go to IDLE.
- Advance out of A_* / D_READ only when ready_i=1, because that is the cycle the previous data phase completes. While ready_i=0, all bus outputs hold their values (addr, write, sel, trans, wdata).
- Type cache: on a completed type write with resp_i=0, cache type and set valid. Any error in a job clears the cache valid bit.
- Error: resp_i=1 with ready_i=1 sets a sticky err flag for the job.
  - Transfers already in address phase still complete (bus-legal). No new transfer is issued after the cycle the error is seen.
  - The FSM jumps to D_READ if a read address is pending, else to RESP.
  - rsp_err_o=1, rsp_data_o=0. The flag clears on response handshake.
- wdata_o is 0 when not in a write data phase.

## Timing

- Reset values: cmd_ready_o=1 (IDLE), rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, sel_o=trans_o=write_o=0, addr_o=0, wdata_o=0, cache invalid.
- Reset mid-job: the bus returns to idle immediately (async). The job is dropped with no response, and the cache is invalidated.
- Zero-wait latency, with command accepted at edge N:
  - A_TYPE is presented in cycle N+1, A_INPUT in N+2, A_READ in N+3, D_READ in N+4.
  - rsp_valid_o=1 in cycle N+5.
- With a cache hit, latency is 4 cycles.
- Each wait cycle (ready_i=0) adds exactly one cycle.
- Back-to-back: the next command can be accepted in the cycle after the response handshake, since IDLE lasts ≥1 cycle.
- ready_o = ready_i, with no register.

## Test plan

- Reset, then cmd type=1, data=0x0000_0010, slave returns 0x10, no waits -> bus addrs 0x0,0x4,0x8 in consecutive cycles; wdata 1 then 0x10; rsp_valid at N+5, rsp_data=0x10, err=0.
- Repeat the same type=1 with data=0xFFFF_FFF0 -> no type write; first address is 0x4; rsp_valid at N+4.
- Two wait cycles (ready_i=0) during the input-write data phase -> addr_o=0x8 and wdata_o=data held 3 cycles; latency 7.
- resp_i=1 on the type write -> input write still completes; no read issued; rsp_err=1, rsp_data=0; next job with the same type writes 0x0 again.
- rsp_ready_i low for 3 cycles -> rsp_valid/rsp_data stable; cmd_ready_o=0 until handshake.
- rst_ni asserted during A_INPUT -> outputs immediately at reset values; no response produced; next job writes type.

Source files
------------

// File: rtl/npu_bus_master.sv
// Bus initiator for one NPU activation job: pipelined write Type, write Input, read Output.
// Keeps a one-entry type cache so that repeated activation types skip the type write.
module npu_bus_master #(
    parameter int unsigned       DWidth     = 32,
    parameter logic [DWidth-1:0] TypeAddr   = 'h0,
    parameter logic [DWidth-1:0] InputAddr  = 'h4,
    parameter logic [DWidth-1:0] OutputAddr = 'h8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DWidth-1:0] cmd_type_i,
    input  logic [DWidth-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWidth-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              sel_o,
    output logic              trans_o,
    output logic              write_o,
    output logic [DWidth-1:0] addr_o,
    output logic [DWidth-1:0] wdata_o,
    output logic              ready_o,
    input  logic [DWidth-1:0] rdata_i,
    input  logic              resp_i,
    input  logic              ready_i
);

    typedef enum logic [2:0] {IDLE, A_TYPE, A_INPUT, A_READ, D_READ, RESP} state_e;
    typedef enum logic [1:0] {DP_NONE, DP_TYPE, DP_INPUT, DP_READ} dphase_e;

    state_e            state_q, state_d;
    dphase_e           dphase_q, dphase_d;
    logic              err_q, err_d;
    logic              dp_err, cache_hit;
    logic              cache_valid_q;
    logic [DWidth-1:0] cache_type_q, type_q, data_q;
    logic              sel_d, write_d;
    logic [DWidth-1:0] addr_d, wdata_d;

    assign ready_o   = ready_i;
    assign dp_err    = ready_i && resp_i && (dphase_q != DP_NONE);
    assign cache_hit = cache_valid_q && (cmd_type_i == cache_type_q);

    // State register; dphase tracks which transfer currently owns the data phase
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            dphase_q <= DP_NONE;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dphase_q <= dphase_d;
            err_q    <= err_d;
        end
    end

    // Next state: every bus state advances only on the cycle the data phase completes
    always_comb begin
        state_d  = state_q;
        dphase_d = dphase_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d  = cache_hit ? A_INPUT : A_TYPE;
                    dphase_d = DP_NONE;
                    err_d    = 1'b0;
                end
            end
            A_TYPE: begin
                if (ready_i) begin
                    state_d  = A_INPUT;
                    dphase_d = DP_TYPE;
                end
            end
            A_INPUT: begin
                if (ready_i) begin
                    state_d  = dp_err ? D_READ : A_READ;
                    dphase_d = DP_INPUT;
                end
            end
            A_READ: begin
                if (ready_i) begin
                    state_d  = D_READ;
                    dphase_d = DP_READ;
                end
            end
            D_READ: begin
                if (ready_i) begin
                    state_d  = RESP;
                    dphase_d = DP_NONE;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                dphase_d = DP_NONE;
            end
        endcase
        if (dp_err) err_d = 1'b1;
    end

    // Bus outputs decoded from the next state so they can be registered
    always_comb begin
        sel_d   = 1'b0;
        write_d = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            A_TYPE:  begin sel_d = 1'b1; write_d = 1'b1; addr_d = TypeAddr;  end
            A_INPUT: begin sel_d = 1'b1; write_d = 1'b1; addr_d = InputAddr; end
            A_READ:  begin sel_d = 1'b1; addr_d = OutputAddr; end
            default: ;
        endcase
        case (dphase_d)
            DP_TYPE:  wdata_d = type_q;
            DP_INPUT: wdata_d = data_q;
            default:  wdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            sel_o       <= 1'b0;
            trans_o     <= 1'b0;
            write_o     <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
        end else begin
            cmd_ready_o <= (state_d == IDLE);
            rsp_valid_o <= (state_d == RESP);
            rsp_err_o   <= (state_d == RESP) && err_d;
            sel_o       <= sel_d;
            trans_o     <= sel_d;
            write_o     <= write_d;
            addr_o      <= addr_d;
            wdata_o     <= wdata_d;
        end
    end

    // Command latch, type cache and response data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            type_q        <= '0;
            data_q        <= '0;
            cache_type_q  <= '0;
            cache_valid_q <= 1'b0;
            rsp_data_o    <= '0;
        end else begin
            if (state_q == IDLE && cmd_valid_i) begin
                type_q <= cmd_type_i;
                data_q <= cmd_data_i;
            end
            if (dp_err) begin
                cache_valid_q <= 1'b0;
            end else if (ready_i && dphase_q == DP_TYPE) begin
                cache_valid_q <= 1'b1;
                cache_type_q  <= type_q;
            end
            if (state_q == D_READ && ready_i) begin
                rsp_data_o <= err_d ? '0 : rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_npu_bus_master.sv
// Randomized bench for npu_bus_master: a bus slave model plus a job-level reference
// model (transfer list, latency, result and type cache) derived from the job rules.
module tb_npu_bus_master;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i, cmd_ready_o;
    logic [31:0] cmd_type_i, cmd_data_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        sel_o, trans_o, write_o;
    logic [31:0] addr_o, wdata_o;
    logic        ready_o;
    logic [31:0] rdata_i;
    logic        resp_i, ready_i;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_cache_valid;
    logic [31:0] m_cache_type;

    always #5 clk = ~clk;

    npu_bus_master dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_type_i(cmd_type_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .sel_o(sel_o), .trans_o(trans_o), .write_o(write_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .ready_o(ready_o),
        .rdata_i(rdata_i), .resp_i(resp_i), .ready_i(ready_i)
    );

    // Transfer kinds: 1 = type write, 2 = input write, 3 = output read
    function automatic int kind_of(input logic [31:0] a);
        if (a == 32'h0) return 1;
        if (a == 32'h4) return 2;
        if (a == 32'h8) return 3;
        return 0;
    endfunction

    function automatic int code_of(input int k);
        if (k == 1) return 5;
        if (k == 2) return 6;
        return 3;
    endfunction

    task automatic check_reset_values(input string name);
        n_cmp++;
        if ({cmd_ready_o, rsp_valid_o, rsp_err_o, sel_o, trans_o, write_o} !== 6'b100000) begin
            n_bad++;
            $display("FAIL %s ctrl: got %b want 100000", name,
                     {cmd_ready_o, rsp_valid_o, rsp_err_o, sel_o, trans_o, write_o});
        end
        n_cmp++;
        if (addr_o !== 32'h0 || wdata_o !== 32'h0) begin
            n_bad++;
            $display("FAIL %s bus: got addr=%h wdata=%h want 0/0", name, addr_o, wdata_o);
        end
        n_cmp++;
        if (rsp_data_o !== 32'h0) begin
            n_bad++;
            $display("FAIL %s rsp_data: got %h want 0", name, rsp_data_o);
        end
    endtask

    task automatic run_job(input string name, input logic [31:0] ty, input logic [31:0] dat,
                           input logic [31:0] rval, input int w_ty, input int w_in,
                           input int w_rd, input int err_ph, input int rdelay);
        int          waits[4];
        int          kinds[$];
        int          issued, exp_lat, exp_seq, got_seq, pend, wl, lat, bad_cyc, bad_hold;
        bit          hit, exp_err;
        logic [31:0] exp_data, exp_wd, prev_addr, d0;
        logic        prev_sel, prev_write, prev_ready, e0;

        waits = '{0, w_ty, w_in, w_rd};
        hit = m_cache_valid && (ty == m_cache_type);
        if (!hit) kinds.push_back(1);
        kinds.push_back(2);
        kinds.push_back(3);
        issued = kinds.size();
        for (int i = 0; i < kinds.size(); i++) begin
            if (kinds[i] == err_ph) begin
                issued = (i + 2 < kinds.size()) ? i + 2 : kinds.size();
                break;
            end
        end
        exp_lat = 2; exp_err = 0; exp_seq = 0;
        for (int i = 0; i < issued; i++) begin
            exp_lat += 1 + waits[kinds[i]];
            if (kinds[i] == err_ph) exp_err = 1;
            exp_seq = exp_seq * 8 + code_of(kinds[i]);
        end
        exp_data = exp_err ? 32'h0 : rval;

        cmd_type_i = ty; cmd_data_i = dat; cmd_valid_i = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready_o);
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0; cmd_type_i = $urandom; cmd_data_i = $urandom;

        pend = 0; wl = 0; lat = 0; got_seq = 0; bad_cyc = 0; prev_ready = 1'b1;
        prev_addr = '0; prev_sel = 1'b0; prev_write = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            if (pend != 0 && wl > 0) begin
                ready_i = 1'b0; resp_i = 1'b0;
            end else begin
                ready_i = 1'b1; resp_i = (pend != 0 && pend == err_ph);
            end
            rdata_i = (pend == 3 && ready_i) ? rval : $urandom;
            @(negedge clk);
            if (rsp_valid_o === 1'b1) begin lat = cyc; break; end
            exp_wd = (pend == 1) ? ty : ((pend == 2) ? dat : 32'h0);
            if (wdata_o !== exp_wd) bad_cyc++;
            if (!prev_ready && (addr_o !== prev_addr || sel_o !== prev_sel || write_o !== prev_write))
                bad_cyc++;
            if (cmd_ready_o !== 1'b0 || trans_o !== sel_o || ready_o !== ready_i) bad_cyc++;
            prev_addr = addr_o; prev_sel = sel_o; prev_write = write_o; prev_ready = ready_i;
            if (ready_i) begin
                if (sel_o && trans_o) begin
                    got_seq = got_seq * 8 + int'(addr_o[5:2]) + 1 + (write_o ? 4 : 0);
                    pend = kind_of(addr_o);
                    wl = waits[pend];
                end else begin
                    pend = 0;
                end
            end else begin
                wl--;
            end
        end
        ready_i = 1'b1; resp_i = 1'b0;

        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
            if (lat == 0) begin
                rst_ni = 1'b0; #3; rst_ni = 1'b1;
                m_cache_valid = 0;
                @(posedge clk); #1;
                return;
            end
        end
        n_cmp++;
        if (got_seq != exp_seq) begin
            n_bad++;
            $display("FAIL %s addr_seq: got %0o want %0o", name, got_seq, exp_seq);
        end
        n_cmp++;
        if (bad_cyc != 0) begin
            n_bad++;
            $display("FAIL %s bus_cycles: got %0d bad cycles want 0", name, bad_cyc);
        end
        n_cmp++;
        if (rsp_data_o !== exp_data) begin
            n_bad++;
            $display("FAIL %s rsp_data: got %h want %h", name, rsp_data_o, exp_data);
        end
        n_cmp++;
        if (rsp_err_o !== exp_err) begin
            n_bad++;
            $display("FAIL %s rsp_err: got %b want %b", name, rsp_err_o, exp_err);
        end

        d0 = rsp_data_o; e0 = rsp_err_o; bad_hold = 0;
        for (int i = 0; i < rdelay; i++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== d0 || rsp_err_o !== e0 ||
                cmd_ready_o !== 1'b0 || sel_o !== 1'b0)
                bad_hold++;
        end
        if (rdelay > 0) begin
            n_cmp++;
            if (bad_hold != 0) begin
                n_bad++;
                $display("FAIL %s rsp_hold: got %0d unstable cycles want 0", name, bad_hold);
            end
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        n_cmp++;
        if ({rsp_valid_o, rsp_err_o, cmd_ready_o} !== 3'b001) begin
            n_bad++;
            $display("FAIL %s after_handshake: got %b want 001", name,
                     {rsp_valid_o, rsp_err_o, cmd_ready_o});
        end

        if (exp_err) m_cache_valid = 0;
        else if (!hit) begin m_cache_valid = 1; m_cache_type = ty; end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_type_i = '0; cmd_data_i = '0;
        rsp_ready_i = 1'b0; rdata_i = '0; resp_i = 1'b0; ready_i = 1'b1;
        m_cache_valid = 0; m_cache_type = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_job("basic", 32'h1, 32'h0000_0010, 32'h0000_0010, 0, 0, 0, 0, 0);
    endtask

    task automatic test_cache_hit();
        run_job("cache_hit", 32'h1, 32'hFFFF_FFF0, $urandom, 0, 0, 0, 0, 0);
    endtask

    task automatic test_wait_states();
        run_job("wait_input", 32'h2, 32'hA5A5_0001, $urandom, 0, 2, 0, 0, 0);
        run_job("wait_all", 32'h7, 32'h0BAD_F00D, $urandom, 1, 1, 2, 0, 0);
    endtask

    task automatic test_error();
        run_job("err_type", 32'h3, 32'h1234_5678, $urandom, 0, 0, 0, 1, 0);
        run_job("err_retry", 32'h3, 32'h1111_2222, $urandom, 0, 0, 0, 0, 0);
        run_job("err_read", 32'h3, 32'h3333_4444, $urandom, 0, 0, 1, 3, 0);
        run_job("err_input", 32'h3, 32'h5555_6666, $urandom, 0, 1, 0, 2, 0);
    endtask

    task automatic test_backpressure();
        run_job("rsp_backpressure", 32'h4, 32'hCAFE_0000, $urandom, 0, 0, 0, 0, 3);
    endtask

    task automatic test_back_to_back();
        run_job("b2b_first", 32'h4, 32'h0000_0001, $urandom, 0, 0, 0, 0, 0);
        run_job("b2b_second", 32'h4, 32'h0000_0002, $urandom, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_job();
        int seen_rsp;
        ready_i = 1'b1; resp_i = 1'b0;
        cmd_type_i = 32'h5; cmd_data_i = 32'hDEAD_BEEF; cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(posedge clk); #2;
        n_cmp++;
        if ({sel_o, write_o} !== 2'b11 || addr_o !== 32'h4) begin
            n_bad++;
            $display("FAIL mid_reset pre: got sel/write=%b addr=%h want 11/00000004",
                     {sel_o, write_o}, addr_o);
        end
        rst_ni = 1'b0;
        #1;
        check_reset_values("mid_reset");
        seen_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0) seen_rsp++;
        end
        rst_ni = 1'b1;
        m_cache_valid = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0) seen_rsp++;
        end
        n_cmp++;
        if (seen_rsp != 0) begin
            n_bad++;
            $display("FAIL mid_reset no_rsp: got %0d cycles with rsp_valid want 0", seen_rsp);
        end
        @(posedge clk); #1;
        run_job("after_reset", 32'h5, 32'h0000_00AA, $urandom, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int ep;
            ep = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_job("random", 32'($urandom_range(0, 3)), $urandom, $urandom,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), ep, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_cache_hit();
        test_wait_states();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_job();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
